// File: rtl/readout.sv
// -----------------------------------------------------------------------------
// readout: per-scanline VRAM fetch sequencer for the text-mode display path.
//
// Each visible scanline walks one text row of VRAM. Every 8-clock character
// cell issues a character read (even address) and an attribute read (odd
// address). The cell phase and burst flag go to the pixel generator.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            synchronous reset, active-high
//   i_frame_start    1-clk pulse, rewinds the row base to 0
//   i_fetch_start    1-clk pulse, starts (or restarts) a scanline burst
//   i_v_count        scanline index within the character row (0..15)
//   o_readout_count  cell phase (0..7) to the pixel generator
//   o_active         burst in progress
//   o_vram_rd_en     VRAM read strobe
//   o_vram_rd_addr   VRAM read address
//   o_line_done      1-clk pulse after the last cell of a completed burst
// -----------------------------------------------------------------------------
module readout #(
    parameter int COLS = 80,
    parameter int ROWS = 30,
    parameter int AW   = 13
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_frame_start,
    input  logic          i_fetch_start,
    input  logic [3:0]    i_v_count,
    output logic [2:0]    o_readout_count,
    output logic          o_active,
    output logic          o_vram_rd_en,
    output logic [AW-1:0] o_vram_rd_addr,
    output logic          o_line_done
);

    localparam int            CW          = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] LAST_COL    = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_ONE     = CW'(1);
    localparam logic [AW-1:0] ROW_STEP    = AW'(2 * COLS);
    localparam logic [AW-1:0] FRAME_WORDS = AW'(ROWS * COLS * 2);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t        r_state,    w_state_nxt;
    logic [2:0]    r_count,    w_count_nxt;
    logic [CW-1:0] r_col,      w_col_nxt;
    logic [AW-1:0] r_row_base, w_row_base_nxt;
    logic          r_rd_en,    w_rd_en_nxt;
    logic [AW-1:0] r_rd_addr,  w_rd_addr_nxt;
    logic          r_line_done, w_line_done_nxt;

    logic [AW-1:0] w_row_adv;
    logic [AW-1:0] w_row_wrapped;
    logic [AW-1:0] w_base_adv;
    logic [AW-1:0] w_col_off;
    logic          w_attr;

    // Next-state logic: burst sequencing, row-base bookkeeping and read strobes.
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count + 3'd1;
        w_col_nxt       = r_col;
        w_base_adv      = r_row_base;
        w_rd_en_nxt     = 1'b0;
        w_rd_addr_nxt   = r_rd_addr;
        w_line_done_nxt = 1'b0;

        w_row_adv     = r_row_base + ROW_STEP;
        w_row_wrapped = (w_row_adv == FRAME_WORDS) ? {AW{1'b0}} : w_row_adv;
        w_col_off     = AW'({r_col, 1'b0});
        w_attr        = (r_count == 3'd5);

        if (i_fetch_start) begin
            // Start or restart: realign phase, rewind the cell counter; an
            // aborted burst neither reports lineDone nor advances the row.
            w_state_nxt = ST_FETCH;
            w_count_nxt = 3'd0;
            w_col_nxt   = {CW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_FETCH: begin
                    if (r_count == 3'd7) begin
                        if (r_col == LAST_COL) begin
                            w_state_nxt     = ST_IDLE;
                            w_col_nxt       = {CW{1'b0}};
                            w_line_done_nxt = 1'b1;
                            if (i_v_count == 4'd15) begin
                                w_base_adv = w_row_wrapped;
                            end else begin
                                w_base_adv = r_row_base;
                            end
                        end else begin
                            w_col_nxt = r_col + COL_ONE;
                        end
                    end else begin
                        w_col_nxt = r_col;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // frameStart beats a coincident row advance.
        w_row_base_nxt = i_frame_start ? {AW{1'b0}} : w_base_adv;

        // Strobes are registered, so decode one phase early (1 -> char at
        // phase 2, 5 -> attr at phase 6). The address uses next cycle's base
        // so a mid-burst frameStart takes effect on the very next read.
        if (!i_fetch_start && (r_state == ST_FETCH) &&
            ((r_count == 3'd1) || (r_count == 3'd5))) begin
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = w_row_base_nxt + w_col_off + {{(AW-1){1'b0}}, w_attr};
        end else begin
            w_rd_en_nxt   = 1'b0;
            w_rd_addr_nxt = r_rd_addr;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_count     <= 3'd0;
            r_col       <= {CW{1'b0}};
            r_row_base  <= {AW{1'b0}};
            r_rd_en     <= 1'b0;
            r_rd_addr   <= {AW{1'b0}};
            r_line_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_col       <= w_col_nxt;
            r_row_base  <= w_row_base_nxt;
            r_rd_en     <= w_rd_en_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_line_done <= w_line_done_nxt;
        end
    end

    assign o_readout_count = r_count;
    assign o_active        = (r_state == ST_FETCH);
    assign o_vram_rd_en    = r_rd_en;
    assign o_vram_rd_addr  = r_rd_addr;
    assign o_line_done     = r_line_done;

endmodule

// File: tb/tb_readout.sv
// -----------------------------------------------------------------------------
// tb_readout: self-checking bench for readout.
// The reference model tracks bursts by cycle index (burst start, phase origin,
// row base as an integer) and derives expected outputs with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_readout;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int AW    = 13;
    localparam int LINE  = COLS * 8;
    localparam int FRAME = ROWS * COLS * 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          fs;
    logic          frs;
    logic [3:0]    vc;
    logic [2:0]    o_cnt;
    logic          o_act;
    logic          o_rd;
    logic [AW-1:0] o_addr;
    logic          o_done;

    always #5 clk = ~clk;

    readout #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_frame_start   (frs),
        .i_fetch_start   (fs),
        .i_v_count       (vc),
        .o_readout_count (o_cnt),
        .o_active        (o_act),
        .o_vram_rd_en    (o_rd),
        .o_vram_rd_addr  (o_addr),
        .o_line_done     (o_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int n       = 0;
    int align_c = 0;
    int t0      = 0;
    int done_at = -1;
    int base    = 0;
    int exp_addr = 0;
    bit in_burst = 1'b0;

    // per-burst statistics observed from the DUT
    int st_strobes, st_active, st_done, st_first, st_last;
    bit st_first_pend;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic clear_stats();
        st_strobes = 0; st_active = 0; st_done = 0;
        st_first = -1; st_last = -1; st_first_pend = 1'b1;
    endtask

    // Advance the model across one rising edge using the sampled inputs.
    task automatic model_step();
        int c;
        c = n;
        n = n + 1;
        if (rst) begin
            align_c = n; in_burst = 1'b0; base = 0; exp_addr = 0; done_at = -1;
        end else begin
            if (in_burst && !fs && (c - t0) == LINE - 1) begin
                in_burst = 1'b0;
                done_at  = n;
                if (vc == 4'd15) base = (base + 2 * COLS) % FRAME;
            end
            if (fs) begin
                t0 = n; align_c = n; in_burst = 1'b1;
            end
            if (frs) base = 0;
        end
    endtask

    task automatic compare();
        int ph;
        bit e_rd;
        ph   = (n - align_c) % 8;
        e_rd = in_burst && (ph == 2 || ph == 6);
        if (e_rd) exp_addr = base + 2 * ((n - t0) / 8) + ((ph == 6) ? 1 : 0);
        check_eq("readoutCount", int'(o_cnt), ph);
        check_eq("active", int'(o_act), int'(in_burst));
        check_eq("vramRdEn", int'(o_rd), int'(e_rd));
        check_eq("vramRdAddr", int'(o_addr), exp_addr);
        check_eq("lineDone", int'(o_done), (n == done_at) ? 1 : 0);
        if (o_rd) begin
            st_strobes++;
            st_last = int'(o_addr);
            if (st_first_pend) begin
                st_first = int'(o_addr);
                st_first_pend = 1'b0;
            end
        end
        if (o_act)  st_active++;
        if (o_done) st_done++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        fs = 1'b0; frs = 1'b0; rst = 1'b0;
    endtask

    // One full burst plus two trailing idle cycles; optional frameStart on the final edge.
    task automatic burst(input int v, input bit frs_end);
        vc = 4'(v);
        clear_stats();
        fs = 1'b1;
        tick();
        repeat (LINE - 1) tick();
        if (frs_end) frs = 1'b1;
        tick();
        repeat (2) tick();
    endtask

    initial begin
        int pre;
        fs = 1'b0; frs = 1'b0; vc = 4'd0; rst = 1'b1;
        repeat (3) begin rst = 1'b1; tick(); end
        check_eq("rst_count", int'(o_cnt), 0);
        check_eq("rst_active", int'(o_act), 0);
        check_eq("rst_rden", int'(o_rd), 0);
        check_eq("rst_addr", int'(o_addr), 0);
        check_eq("rst_done", int'(o_done), 0);

        // basic burst
        repeat (7) tick();
        burst(0, 1'b0);
        check_eq("basic_strobes", st_strobes, 160);
        check_eq("basic_active", st_active, LINE);
        check_eq("basic_done", st_done, 1);
        check_eq("basic_first", st_first, 0);
        check_eq("basic_last", st_last, 159);

        // row advance across vCount 1..15
        for (int v = 1; v < 16; v++) begin
            burst(v, 1'b0);
            check_eq("rowadv_base0", st_first, 0);
        end
        burst(0, 1'b0);
        check_eq("rowadv_next", st_first, 160);

        // reset mid-burst at cell 40
        vc = 4'd0; clear_stats(); fs = 1'b1; tick();
        repeat (40 * 8) tick();
        rst = 1'b1; tick();
        check_eq("midrst_active", int'(o_act), 0);
        check_eq("midrst_rden", int'(o_rd), 0);
        check_eq("midrst_addr", int'(o_addr), 0);
        check_eq("midrst_count", int'(o_cnt), 0);
        repeat (10) tick();
        check_eq("midrst_nodone", st_done, 0);
        burst(0, 1'b0);
        check_eq("midrst_base", st_first, 0);

        // row base wrap
        for (int r = 0; r < 29; r++) burst(15, 1'b0);
        burst(0, 1'b0);
        check_eq("wrap_row29", st_first, 4640);
        burst(15, 1'b0);
        burst(0, 1'b0);
        check_eq("wrap_to0", st_first, 0);

        // frameStart between bursts, then coincident with a row advance
        for (int r = 0; r < 5; r++) burst(15, 1'b0);
        burst(0, 1'b0);
        check_eq("frs_row5", st_first, 800);
        frs = 1'b1; tick();
        repeat (4) tick();
        burst(0, 1'b0);
        check_eq("frs_idle", st_first, 0);
        for (int r = 0; r < 5; r++) burst(15, 1'b0);
        burst(15, 1'b1);
        check_eq("frs_coinc_pre", st_first, 800);
        burst(0, 1'b0);
        check_eq("frs_coinc", st_first, 0);

        // retrigger at cell 20 phase 4
        burst(15, 1'b0);
        vc = 4'd0; clear_stats(); fs = 1'b1; tick();
        repeat (164) tick();
        check_eq("retrig_phase", int'(o_cnt), 4);
        pre = st_strobes;
        st_strobes = 0; st_active = 0; st_first_pend = 1'b1;
        fs = 1'b1; tick();
        check_eq("retrig_count0", int'(o_cnt), 0);
        repeat (LINE + 1) tick();
        check_eq("retrig_pre_strobes", pre, 41);
        check_eq("retrig_strobes", st_strobes, 160);
        check_eq("retrig_active", st_active, LINE);
        check_eq("retrig_done", st_done, 1);
        check_eq("retrig_first", st_first, 160);

        // randomized bursts with stray frameStart / fetchStart / reset
        for (int b = 0; b < 12; b++) begin
            vc = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            fs = 1'b1;
            tick();
            for (int k = 0; k < LINE + 2; k++) begin
                if ($urandom_range(0, 399) == 0)  frs = 1'b1;
                if ($urandom_range(0, 999) == 0)  fs  = 1'b1;
                if ($urandom_range(0, 2999) == 0) rst = 1'b1;
                tick();
            end
            repeat ($urandom_range(1, 20)) begin
                if ($urandom_range(0, 9) == 0) frs = 1'b1;
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/readout.md
Name: readout

Overview:
- Upstream neighbour of the pixel generator in the FPGA display controller.
- Per visible scanline, walks one text row of VRAM. Each 8-clock character cell yields one character-byte read and one attribute-byte read.
- Drives readoutCount and active to the pixel generator, and vramRdEn and vramRdAddr to the VRAM read port.
- VRAM layout is interleaved: char at even address, attr at the following odd address. Rows are contiguous.

Parameters:
- COLS, 80, character cells per text row.
- ROWS, 30, text rows per frame.
- AW, 13, VRAM address width; must satisfy 2^AW >= ROWS*COLS*2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- frameStart  in  1  one-clock pulse at start of frame; rewinds row base to 0.
- fetchStart  in  1  one-clock pulse from timing generator, issued 8 clocks before first visible pixel of a visible scanline.
- vCount  in  4  scanline index within the current character row (0..15); stable during a burst.
- readoutCount  out  3  cell phase to pixel generator.
- active  out  1  fetch burst in progress.
- vramRdEn  out  1  VRAM read strobe.
- vramRdAddr  out  AW  VRAM read address.
- lineDone  out  1  one-clock pulse after the last cell of a burst.

Behaviour:
- Reset values (rst high at an edge): readoutCount=0, active=0, vramRdEn=0, vramRdAddr=0, lineDone=0, col=0, rowBase=0. Reset overrides all other inputs, including mid-burst.
- readoutCount is a registered free-running mod-8 counter. It increments every clock and wraps 7->0.
- fetchStart sampled high forces readoutCount=0 on the following cycle (cycle T). This realigns the cell phase.
- States:
  - IDLE: active=0.
  - FETCH: active=1.
  - IDLE->FETCH on fetchStart. active=1 from cycle T through T+COLS*8-1 inclusive, i.e. exactly COLS*8 clocks.
  - FETCH->IDLE after the readoutCount==7 cycle of cell COLS-1. lineDone=1 in the first IDLE cycle only.
- Cell counter col: 0..COLS-1, advances on each readoutCount 7->0 transition while in FETCH. Cleared on fetchStart.
- VRAM timing: one-cycle synchronous read latency. The pixel generator captures data at readoutCount 3 (char) and 7 (attr).
  - readoutCount==2: vramRdEn=1, vramRdAddr=rowBase+2*col (char).
  - readoutCount==6: vramRdEn=1, vramRdAddr=rowBase+2*col+1 (attr).
  - vramRdEn=0 at every other phase and throughout IDLE.
  - vramRdAddr holds its last value while vramRdEn=0.
- Address arithmetic is unsigned, AW bits. 2*col uses a shift; no multiplier.
- rowBase update: at the FETCH->IDLE transition, if vCount==15, rowBase += 2*COLS. If the result equals ROWS*COLS*2, wrap to 0.
- frameStart sets rowBase=0 next cycle. If it coincides with a rowBase advance, frameStart wins.
- frameStart and fetchStart together: the burst starts and uses rowBase=0.
- fetchStart during FETCH: restart the burst from col=0, readoutCount=0. No lineDone and no rowBase advance for the aborted burst.
- frameStart during FETCH: rowBase=0 takes effect immediately; the remaining cells of the burst address from base 0.

Test Plan:
- Basic burst: reset, then fetchStart at cycle 10 (T=11), vCount=0 -> active high on cycles 11..650. vramRdEn at 13 (addr 0) and 17 (addr 1). Cell 79 reads at 645 (addr 158) and 649 (addr 159). lineDone at 651. Exactly 160 strobes.
- Row advance: 16 bursts with vCount=0..15 -> bursts 0..15 use base 0; the 17th burst first char addr is 160.
- Wrap: 30 rows of 16 bursts each, no frameStart -> row 29 base 4640; next burst base 0.
- frameStart: during row 5 (base 800), pulse frameStart between bursts -> next burst first addr 0. Also frameStart coinciding with the vCount==15 burst end -> base 0, not 960.
- Retrigger: fetchStart again at cell 20, phase 4 -> readoutCount=0 next cycle, next char addr rowBase+0, active continuous. 640 active clocks counted from the retrigger. One lineDone only.
- Reset mid-burst: rst high at cell 40 -> next cycle active=0, vramRdEn=0, vramRdAddr=0, readoutCount=0. No lineDone. Next burst base 0.
